snn_delay_layer_param: RTL
==========================

Name: snn_delay_layer_param

Overview:
Parametrised leaky integrate-and-fire (LIF) spiking layer with programmable per-synapse axonal delays. It is the generalised successor to the fixed two-layer delay network. It has M inputs and N neurons, signed weights of configurable width, and a per-input spike history buffer advanced by a single-clock tick strobe instead of a second clock. Layers are cascaded by connecting output_spikes of one instance to input_spikes of the next.

Parameters:
M, 16, number of input spike channels
N, 8, number of neurons
WW, 8, weight width (signed two's complement)
DW, 3, delay value width; history depth D = 2^DW
PW, 8, membrane potential width (unsigned)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  global update enable; when low, all state holds
delay_tick  input  1  one-cycle strobe that advances the spike history
input_spikes  input  M  current input spikes
weights  input  N*M*WW  weight (n,m) at bits [(n*M+m)*WW +: WW]
delay_values  input  N*M*DW  delay d(n,m) at bits [(n*M+m)*DW +: DW]
delay_en  input  N*M  per-synapse delay select; 0 = undelayed
threshold  input  PW  firing threshold, shared by all neurons
decay  input  PW  leak subtracted each update
refractory_period  input  8  refractory length in update cycles
membrane_potential_out  output  N*PW  potential of neuron n at bits [n*PW +: PW]
output_spikes  output  N  registered spike per neuron
spike_count  output  N*8  per-neuron spike counters (see Optional Feature)

Behaviour:
- Reset (clk edge with reset=1): all history bits = 0, potentials = 0, refractory counters = 0, output_spikes = 0, spike_count = 0. Reset has priority over enable and delay_tick.
- History: H[m] is D bits wide. On a cycle with enable & delay_tick, H[m] <= {H[m][D-2:0], input_spikes[m]}. A tick with enable=0 is ignored.
- Effective synapse spike s(n,m) = delay_en ? H[m][d(n,m)] : input_spikes[m].
  - d=0 with delay enabled gives the spike sampled at the most recent tick.
  - Maximum delay is D ticks.
- Neuron update happens on each clk with enable=1. Per neuron n:
  - If ref_cnt>0: ref_cnt <= ref_cnt-1, potential <= 0, spike <= 0. Input is discarded.
  - Otherwise, compute the sum in a signed accumulator of width PW+WW+clog2(M)+1:
    sum = potential + Σ_m s(n,m)·weight(n,m) − decay
    Clamp the sum to [0, 2^PW−1].
  - If clamped >= threshold: spike <= 1, potential <= 0, ref_cnt <= refractory_period.
  - Else: spike <= 0, potential <= clamped.
- Latency: one clk from input_spikes to output_spikes when delay_en=0. With delay enabled, the spike appears after the (d+1)-th tick plus one clk.
- output_spikes is a 1-cycle pulse per firing update. With enable=0, outputs hold their last values.
- threshold=0: the neuron fires on every non-refractory update.
- refractory_period=0: the neuron integrates on the very next update.
- Simultaneous tick and update in the same cycle: the update uses the pre-shift history, so the new sample becomes visible next cycle.
- Configuration inputs are sampled live every update; changing them mid-operation takes effect on the next update with no glitch state.
- Reset asserted mid-refractory or mid-integration clears all state in the same cycle.

Optional Feature:
Macro SNN_SPIKE_COUNT_EN.
- Defined: spike_count[n*8 +: 8] increments on each output spike of neuron n. It saturates at 255 and is cleared by reset.
- Undefined: spike_count is tied to 0 and no counter registers are built.

Test Plan:
- Reset check: apply reset for 2 cycles with random configuration → all outputs 0. Then release with enable=0 and toggle delay_tick → outputs stay 0, and the history is still 0 when later probed via delay_en=1, d=0.
- Undelayed integrate and fire: N0 with weight(0,0)=+40, threshold=100, decay=5, refractory_period=2, delay_en=0, input 0 held high.
  - Potentials: 35, 70.
  - Spike on the 3rd update, potential=0.
  - Two refractory updates at 0.
  - Then 35 again.
- Delay line: delay_en(0,0)=1, d=3, single input pulse latched at tick t → s(0,0) is high between tick t+3 and tick t+4. Checking with threshold=1 and weight=+10, the spike appears exactly once.
- Inhibition and clamp: weight=−60, potential=20, decay=0 → potential clamps to 0, no spike. Weight=+127 on 4 inputs with PW=8 and threshold=255 → clamps to 255 and fires.
- Simultaneous tick and update: pulse present while delay_tick=1 and d=0 → not seen in the same cycle, seen in the next update.
- SNN_SPIKE_COUNT_EN: threshold=0, refractory_period=0, 300 updates → spike_count[7:0] = 255. Without the macro → spike_count = 0.

Source files
------------

// File: rtl/snn_delay_layer_param_if.sv
// Bundles the spiking-layer configuration, input and output signals.
// The master modport drives stimulus and configuration; the slave modport belongs to the layer.
interface snn_delay_layer_param_if #(
   parameter int unsigned M  = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned WW = 8,
   parameter int unsigned DW = 3,
   parameter int unsigned PW = 8
);
   logic                enable;
   logic                delay_tick;
   logic [M-1:0]        input_spikes;
   logic [N*M*WW-1:0]   weights;
   logic [N*M*DW-1:0]   delay_values;
   logic [N*M-1:0]      delay_en;
   logic [PW-1:0]       threshold;
   logic [PW-1:0]       decay;
   logic [7:0]          refractory_period;
   logic [N*PW-1:0]     membrane_potential_out;
   logic [N-1:0]        output_spikes;
   logic [N*8-1:0]      spike_count;

   modport master (
      output enable, delay_tick, input_spikes, weights, delay_values, delay_en,
             threshold, decay, refractory_period,
      input  membrane_potential_out, output_spikes, spike_count
   );

   modport slave (
      input  enable, delay_tick, input_spikes, weights, delay_values, delay_en,
             threshold, decay, refractory_period,
      output membrane_potential_out, output_spikes, spike_count
   );
endinterface

// File: rtl/snn_delay_layer_param.sv
// LIF spiking layer with per-synapse axonal delays taken from a tick-advanced spike history.
// Optional per-neuron saturating spike counters are built when SNN_SPIKE_COUNT_EN is defined.
module snn_delay_layer_param #(
   parameter int unsigned M  = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned WW = 8,
   parameter int unsigned DW = 3,
   parameter int unsigned PW = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   snn_delay_layer_param_if.slave bus
);
   localparam int unsigned D  = 1 << DW;
   localparam int unsigned AW = PW + WW + $clog2(M) + 1;
   localparam int unsigned RW = 8;
   localparam int unsigned CW = 8;
   localparam logic signed [AW-1:0] PMAX = signed'(AW'({PW{1'b1}}));

   logic [D-1:0]         r_hist [M];
   logic [PW-1:0]        r_pot  [N];
   logic [RW-1:0]        r_ref  [N];
   logic [N-1:0]         r_spk;

   logic [M-1:0]         w_syn   [N];
   logic signed [AW-1:0] w_sum   [N];
   logic [PW-1:0]        w_clamp [N];
   logic [N-1:0]         w_fire;

   // Synapse selection, weighted sum with leak, clamp to the unsigned potential range
   always_comb begin
      for (int n = 0; n < N; n++) begin
         w_syn[n]   = '0;
         w_sum[n]   = signed'(AW'(r_pot[n])) - signed'(AW'(bus.decay));
         w_clamp[n] = '0;
         for (int m = 0; m < M; m++) begin
            w_syn[n][m] = bus.delay_en[n*M+m]
                        ? r_hist[m][bus.delay_values[(n*M+m)*DW +: DW]]
                        : bus.input_spikes[m];
            if (w_syn[n][m])
               w_sum[n] = w_sum[n] + AW'(signed'(bus.weights[(n*M+m)*WW +: WW]));
         end
         if (w_sum[n] < 0)
            w_clamp[n] = '0;
         else if (w_sum[n] > PMAX)
            w_clamp[n] = '1;
         else
            w_clamp[n] = w_sum[n][PW-1:0];
         w_fire[n] = (r_ref[n] == '0) && (w_clamp[n] >= bus.threshold);
      end
   end

   // History shift and neuron state update; updates see the pre-shift history
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int m = 0; m < M; m++) r_hist[m] <= '0;
         for (int n = 0; n < N; n++) begin
            r_pot[n] <= '0;
            r_ref[n] <= '0;
         end
         r_spk <= '0;
      end else if (bus.enable) begin
         if (bus.delay_tick)
            for (int m = 0; m < M; m++) r_hist[m] <= {r_hist[m][D-2:0], bus.input_spikes[m]};
         for (int n = 0; n < N; n++) begin
            if (r_ref[n] != '0) begin
               r_ref[n] <= r_ref[n] - RW'(1);
               r_pot[n] <= '0;
               r_spk[n] <= 1'b0;
            end else if (w_fire[n]) begin
               r_ref[n] <= bus.refractory_period;
               r_pot[n] <= '0;
               r_spk[n] <= 1'b1;
            end else begin
               r_pot[n] <= w_clamp[n];
               r_spk[n] <= 1'b0;
            end
         end
      end
   end

   assign bus.output_spikes = r_spk;

   for (genvar g = 0; g < N; g++) begin : g_pot
      assign bus.membrane_potential_out[g*PW +: PW] = r_pot[g];
   end

`ifdef SNN_SPIKE_COUNT_EN
   logic [CW-1:0] r_cnt [N];

   // Saturating per-neuron firing counters
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < N; n++) r_cnt[n] <= '0;
      end else if (bus.enable) begin
         for (int n = 0; n < N; n++)
            if (w_fire[n] && (r_cnt[n] != '1)) r_cnt[n] <= r_cnt[n] + CW'(1);
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_cnt
      assign bus.spike_count[g*CW +: CW] = r_cnt[g];
   end
`else
   assign bus.spike_count = '0;
`endif

endmodule
